// File: rtl/rect_pos_ctl.sv
// rtl/rect_pos_ctl.sv - frame-rate rectangle position control: mouse follow, drop, bounce, rest
module rect_pos_ctl #(
  parameter int unsigned X_MAX   = 752,
  parameter int unsigned Y_FLOOR = 536,
  parameter int unsigned ACCEL   = 1,
  parameter int unsigned VMAX    = 16,
  parameter int unsigned VMIN    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] r_xpos,
  output logic [11:0] r_ypos,
  output logic        moving
);

  typedef enum logic [1:0] {FOLLOW, FALL, RISE, REST} state_t;

  state_t      state;
  logic [4:0]  vel;
  logic        vblnk_d;
  logic        btn_d;
  logic        click_pend;

  logic        tick;
  logic        click;
  logic        pend;
  logic [12:0] vel_inc;
  logic [12:0] vn;
  logic [12:0] fall_sum;
  logic [12:0] bounce;
  logic [11:0] rise_y;
  logic [4:0]  rise_v;
  logic [11:0] mx_clamp;
  logic [11:0] my_clamp;

  // A click arriving on the tick cycle itself still counts for that tick.
  always_comb begin
    tick     = vblnk & ~vblnk_d;
    click    = mouse_left & ~btn_d;
    pend     = click_pend | click;
    vel_inc  = 13'(vel) + 13'(ACCEL);
    vn       = (vel_inc > 13'(VMAX)) ? 13'(VMAX) : vel_inc;
    fall_sum = {1'b0, r_ypos} + vn;
    bounce   = vn >> 1;
    rise_y   = ({1'b0, r_ypos} >= 13'(vel)) ? (r_ypos - 12'(vel)) : 12'd0;
    rise_v   = (13'(vel) >= 13'(ACCEL)) ? 5'(13'(vel) - 13'(ACCEL)) : 5'd0;
    mx_clamp = ({1'b0, mouse_xpos} > 13'(X_MAX))   ? 12'(X_MAX)   : mouse_xpos;
    my_clamp = ({1'b0, mouse_ypos} > 13'(Y_FLOOR)) ? 12'(Y_FLOOR) : mouse_ypos;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xpos     <= 12'd0;
      r_ypos     <= 12'd0;
      moving     <= 1'b0;
      vel        <= 5'd0;
      state      <= FOLLOW;
      vblnk_d    <= 1'b0;
      btn_d      <= 1'b0;
      click_pend <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
      btn_d   <= mouse_left;
      if (tick) begin
        click_pend <= 1'b0;
        case (state)
          FOLLOW: begin
            if (pend) begin
              vel    <= 5'd0;
              state  <= FALL;
              moving <= 1'b1;
            end else begin
              r_xpos <= mx_clamp;
              r_ypos <= my_clamp;
              moving <= 1'b0;
            end
          end
          FALL: begin
            if (fall_sum >= 13'(Y_FLOOR)) begin
              r_ypos <= 12'(Y_FLOOR);
              if (bounce < 13'(VMIN)) begin
                vel    <= 5'd0;
                state  <= REST;
                moving <= 1'b0;
              end else begin
                vel    <= 5'(bounce);
                state  <= RISE;
                moving <= 1'b1;
              end
            end else begin
              r_ypos <= 12'(fall_sum);
              vel    <= 5'(vn);
              moving <= 1'b1;
            end
          end
          RISE: begin
            r_ypos <= rise_y;
            vel    <= rise_v;
            moving <= 1'b1;
            if (rise_v == 5'd0) state <= FALL;
          end
          REST: begin
            moving <= 1'b0;
            if (pend) state <= FOLLOW;
          end
          default: state <= FOLLOW;
        endcase
      end else if (click) begin
        click_pend <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rect_pos_ctl.md
Name: rect_pos_ctl

Overview:
- Upstream control stage for the rectangle drawing stage.
- Produces the registered rectangle position (r_xpos, r_ypos) consumed by the rectangle drawer.
- The rectangle follows the mouse. A left click drops it: it falls under constant per-frame acceleration, bounces on the floor with halved speed, and comes to rest.
- Positions update once per frame, at blanking start, so the drawer never sees a position change mid-frame.

Parameters:
- X_MAX, 752, largest allowed r_xpos (800 active width − 48 rect width)
- Y_FLOOR, 536, floor position for r_ypos (600 active height − 64 rect height)
- ACCEL, 1, velocity increment per frame while falling
- VMAX, 16, velocity saturation limit
- VMIN, 2, minimum bounce velocity; a smaller bounce stops motion

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- vblnk  in  1  vertical blanking from the timing chain
- mouse_xpos  in  12  mouse X, already synchronous to clk
- mouse_ypos  in  12  mouse Y, already synchronous to clk
- mouse_left  in  1  left button level, synchronous to clk
- r_xpos  out  12  rectangle left edge, registered
- r_ypos  out  12  rectangle top edge, registered
- moving  out  1  high in FALL or RISE, registered

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-low. All state is in flops cleared by rst.
- Reset values:
  - r_xpos=0, r_ypos=0, moving=0
  - vel=0, state=FOLLOW
  - vblnk_d=0, btn_d=0, click_pend=0
- Frame tick: tick = vblnk & ~vblnk_d, where vblnk_d is vblnk registered.
  - All position, velocity and state updates occur only on the clk edge where tick=1.
  - Outputs are stable for the rest of the frame.
- Click detect: click = mouse_left & ~btn_d.
  - Any click sets click_pend.
  - click_pend is cleared on every tick edge, after it has been evaluated.
  - If a click and a tick occur in the same cycle, the click counts for that tick.
- Arithmetic:
  - vel is 5 bits, unsigned.
  - Sums and comparisons are done in 13 bits; no wrap-around is possible.
  - Clamps use min() against the parameters.
- FSM, evaluated at tick:
  - FOLLOW:
    - r_xpos=min(mouse_xpos, X_MAX), r_ypos=min(mouse_ypos, Y_FLOOR).
    - If click pending: keep the current outputs (no mouse update), vel=0, go to FALL.
  - FALL:
    - vn = min(vel+ACCEL, VMAX).
    - If r_ypos+vn >= Y_FLOOR: r_ypos=Y_FLOOR and b = vn>>1.
      - If b < VMIN: vel=0, go to REST.
      - Else: vel=b, go to RISE.
    - Otherwise: r_ypos += vn, vel=vn.
  - RISE:
    - r_ypos = r_ypos − vel, saturating at 0.
    - vel = vel − ACCEL, saturating at 0.
    - When the new vel is 0, go to FALL.
  - REST:
    - Hold position.
    - If click pending: go to FOLLOW. Mouse tracking resumes on the next tick.
- r_xpos is frozen in FALL, RISE and REST.
- Clicks during FALL or RISE are discarded.
- moving is registered together with the state: 1 iff the next state is FALL or RISE.
- Reset mid-motion: an immediate asynchronous return to the reset values. No tick is needed.
- Mouse beyond the clamp limits: the clamped value is applied; no error is flagged.

Test Plan:
- Reset: assert rst=0 mid-frame while in FALL, vel=7 -> same cycle: r_xpos=r_ypos=0, moving=0. After release, the first tick with mouse (100,200) gives (100,200).
- Clamp: in FOLLOW, mouse (900,700) -> after tick, r_xpos=752, r_ypos=536. No change while vblnk stays high.
- Drop and first bounce: start at y=500, click, ACCEL=1.
  - Fall: y = 501, 503, 506, 510, 515, 521, 528, 536.
  - At the floor, vel=4 and state goes to RISE.
  - Rise: y = 532, 529, 527, 526; vel reaches 0 and state goes to FALL.
  - moving=1 throughout.
- Settle: continuing the previous scenario:
  - Fall: y = 527, 529, 532, 536. Bounce with vel=2 gives RISE: 534, 533.
  - Fall again: 534, 536. Bounce vel=1 < VMIN gives REST; moving=0 and y holds at 536 over 5 further frames.
- Click handling:
  - A click during FALL is ignored and the trajectory is unchanged.
  - A click in REST makes state FOLLOW at the next tick. The following tick loads the mouse position.
  - A click in the same cycle as a tick is honoured at that tick.
- Saturation: start at y=0, VMAX=16 -> vel reaches 16 and stays there. The per-tick Δy is 16 until the floor hit, which gives bounce vel 8.
